// File: rtl/frame_fifo_rd_commit_pkg.sv
// frame_fifo_rd_commit_pkg: pointer arithmetic helpers shared by the transactional-read FIFO.
package frame_fifo_rd_commit_pkg;

    typedef logic [15:0] ptr_w_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic ptr_w_t ptr_diff(input ptr_w_t a, input ptr_w_t b, input int unsigned pw);
        return (a - b) & ptr_w_t'((32'd1 << pw) - 32'd1);
    endfunction

endpackage

// File: rtl/frame_fifo_rd_commit_if.sv
// frame_fifo_rd_commit_if: write, speculative-read and commit/rollback signals of the frame FIFO.
// FRAME_FIFO_RD_LEVEL_EN adds the wr_free/rd_avail level outputs.
interface frame_fifo_rd_commit_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 3
);
    logic [DATAWIDTH-1:0] wr_data;
    logic [DATAWIDTH-1:0] rd_data;
    logic                 we;
    logic                 re;
    logic                 commit;
    logic                 rollback;
    logic                 ovf;
    logic                 unf;
    logic                 ne;
    logic                 full;
`ifdef FRAME_FIFO_RD_LEVEL_EN
    logic [ADDRWIDTH:0]   wr_free;
    logic [ADDRWIDTH:0]   rd_avail;
`endif

    modport master (
        output wr_data, we, re, commit, rollback,
`ifdef FRAME_FIFO_RD_LEVEL_EN
        input  wr_free, rd_avail,
`endif
        input  rd_data, ovf, unf, ne, full
    );

    modport slave (
        input  wr_data, we, re, commit, rollback,
`ifdef FRAME_FIFO_RD_LEVEL_EN
        output wr_free, rd_avail,
`endif
        output rd_data, ovf, unf, ne, full
    );
endinterface

// File: rtl/frame_fifo_rd_commit_ram_sdp_reg.sv
// ram_sdp_reg: simple dual-port RAM, one write port and one registered read port.
module ram_sdp_reg #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 we_i,
    input  logic [ADDRWIDTH-1:0] waddr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [ADDRWIDTH-1:0] raddr_i,
    output logic [DATAWIDTH-1:0] rdata_o
);
    logic [DATAWIDTH-1:0] mem_q [2**ADDRWIDTH];
    logic [DATAWIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_fifo_rd_commit.sv
// frame_fifo_rd_commit: FIFO with speculative pops retired by commit or rewound by rollback.
// Define FRAME_FIFO_RD_LEVEL_EN to add the wr_free/rd_avail level outputs.
module frame_fifo_rd_commit
    import frame_fifo_rd_commit_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 3
) (
    input logic                   clk,
    input logic                   reset_l,
    frame_fifo_rd_commit_if.slave bus
);
    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] DEPTH = PW'(depth_of(ADDRWIDTH));

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_cmt_q, rd_cmt_d;
    logic [PW-1:0] used;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          full, ne, push, pop;

    // Space is owned by the committed pointer, so speculative pops never free it.
    always_comb begin
        used     = PW'(ptr_diff(ptr_w_t'(wr_ptr_q), ptr_w_t'(rd_cmt_q), PW));
        full     = used == DEPTH;
        ne       = wr_ptr_q != rd_ptr_q;
        push     = bus.we && !full;
        pop      = bus.re && ne && !bus.rollback;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = bus.rollback ? rd_cmt_q : rd_ptr_q + PW'(pop);
        rd_cmt_d = (bus.commit && !bus.rollback) ? rd_ptr_d : rd_cmt_q;
        ovf_d    = bus.we && full;
        unf_d    = bus.re && !ne && !bus.rollback;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_cmt_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rd_cmt_q <= rd_cmt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    ram_sdp_reg #(
        .DATAWIDTH(DATAWIDTH),
        .ADDRWIDTH(ADDRWIDTH)
    ) u_ram (
        .clk    (clk),
        .reset_l(reset_l),
        .we_i   (push),
        .waddr_i(wr_ptr_q[ADDRWIDTH-1:0]),
        .wdata_i(bus.wr_data),
        .re_i   (pop),
        .raddr_i(rd_ptr_q[ADDRWIDTH-1:0]),
        .rdata_o(bus.rd_data)
    );

    assign bus.full = full;
    assign bus.ne   = ne;
    assign bus.ovf  = ovf_q;
    assign bus.unf  = unf_q;

`ifdef FRAME_FIFO_RD_LEVEL_EN
    assign bus.wr_free  = DEPTH - used;
    assign bus.rd_avail = PW'(ptr_diff(ptr_w_t'(wr_ptr_q), ptr_w_t'(rd_ptr_q), PW));
`endif
endmodule

// File: tb/tb_frame_fifo_rd_commit.sv
// tb_frame_fifo_rd_commit: directed checks of the transactional-read frame FIFO.
module tb_frame_fifo_rd_commit;
    logic clk = 1'b0;
    logic reset_l;
    int   checks = 0;
    int   errors = 0;

    frame_fifo_rd_commit_if #(.DATAWIDTH(8), .ADDRWIDTH(3)) bus ();

    frame_fifo_rd_commit #(.DATAWIDTH(8), .ADDRWIDTH(3)) dut (
        .clk    (clk),
        .reset_l(reset_l),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.we = 1'b0; bus.re = 1'b0; bus.commit = 1'b0; bus.rollback = 1'b0; bus.wr_data = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] v);
        bus.we = 1'b1; bus.wr_data = v; tick(); bus.we = 1'b0;
    endtask

    task automatic rd();
        bus.re = 1'b1; tick(); bus.re = 1'b0;
    endtask

    task automatic cmt();
        bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        idle();
        tick(); tick();
        checks++;
        if ({bus.ne, bus.full, bus.ovf, bus.unf} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got ne/full/ovf/unf=%b exp 0000", {bus.ne, bus.full, bus.ovf, bus.unf});
        end
        checks++;
        if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", bus.rd_data); end
        reset_l = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) wr(8'(i));
        checks++;
        if ({bus.full, bus.ne} !== 2'b11) begin errors++; $display("FAIL fill_full_ne got %b exp 11", {bus.full, bus.ne}); end
`ifdef FRAME_FIFO_RD_LEVEL_EN
        checks++;
        if ({bus.wr_free, bus.rd_avail} !== {4'd0, 4'd8}) begin
            errors++; $display("FAIL fill_levels got free=%0d avail=%0d exp 0 8", bus.wr_free, bus.rd_avail);
        end
`endif
        bus.re = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (bus.rd_data !== 8'((i <= 8) ? i : 8)) begin
                errors++; $display("FAIL drain_data[%0d] got %0h exp %0h", i, bus.rd_data, (i <= 8) ? i : 8);
            end
            checks++;
            if (bus.unf !== (i == 9)) begin errors++; $display("FAIL drain_unf[%0d] got %b exp %b", i, bus.unf, i == 9); end
        end
        bus.re = 1'b0;
        cmt();
        checks++;
        if ({bus.unf, bus.full, bus.ne} !== 3'b000) begin
            errors++; $display("FAIL drain_after_commit got unf/full/ne=%b exp 000", {bus.unf, bus.full, bus.ne});
        end
    endtask

    task automatic test_overfill();
        for (int i = 1; i <= 9; i++) begin
            wr(8'(i));
            checks++;
            if ({bus.full, bus.ovf} !== {i >= 8, i == 9}) begin
                errors++; $display("FAIL overfill[%0d] got full/ovf=%b%b exp %b%b", i, bus.full, bus.ovf, i >= 8, i == 9);
            end
        end
        tick();
        checks++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got %b exp 0", bus.ovf); end
        for (int i = 1; i <= 8; i++) begin
            rd();
            checks++;
            if (bus.rd_data !== 8'(i)) begin errors++; $display("FAIL overfill_drain[%0d] got %0h exp %0h", i, bus.rd_data, i); end
        end
        checks++;
        if (bus.ne !== 1'b0) begin errors++; $display("FAIL overfill_empty got ne=%b exp 0", bus.ne); end
        cmt();
    endtask

    task automatic test_rollback();
        for (int i = 1; i <= 4; i++) wr(8'(i));
        for (int i = 1; i <= 3; i++) begin
            rd();
            checks++;
            if (bus.rd_data !== 8'(i)) begin errors++; $display("FAIL rb_first[%0d] got %0h exp %0h", i, bus.rd_data, i); end
        end
        bus.rollback = 1'b1; tick(); bus.rollback = 1'b0;
        checks++;
        if ({bus.ne, bus.rd_data} !== {1'b1, 8'h03}) begin
            errors++; $display("FAIL rb_hold got ne=%b data=%0h exp ne=1 data=3", bus.ne, bus.rd_data);
        end
        for (int i = 1; i <= 4; i++) begin
            rd();
            checks++;
            if (bus.rd_data !== 8'(i)) begin errors++; $display("FAIL rb_replay[%0d] got %0h exp %0h", i, bus.rd_data, i); end
        end
        cmt();
        checks++;
        if ({bus.ne, bus.full} !== 2'b00) begin errors++; $display("FAIL rb_commit got ne/full=%b exp 00", {bus.ne, bus.full}); end
`ifdef FRAME_FIFO_RD_LEVEL_EN
        checks++;
        if ({bus.wr_free, bus.rd_avail} !== {4'd8, 4'd0}) begin
            errors++; $display("FAIL rb_levels got free=%0d avail=%0d exp 8 0", bus.wr_free, bus.rd_avail);
        end
`endif
    endtask

    task automatic test_full_hold();
        for (int i = 1; i <= 8; i++) wr(8'(i + 16));
        for (int i = 1; i <= 8; i++) begin
            rd();
            checks++;
            if (bus.rd_data !== 8'(i + 16)) begin errors++; $display("FAIL hold_read[%0d] got %0h exp %0h", i, bus.rd_data, i + 16); end
        end
        checks++;
        if ({bus.full, bus.ne} !== 2'b10) begin errors++; $display("FAIL hold_full got full/ne=%b exp 10", {bus.full, bus.ne}); end
        wr(8'hAA);
        checks++;
        if ({bus.ovf, bus.full} !== 2'b11) begin errors++; $display("FAIL hold_ovf got ovf/full=%b exp 11", {bus.ovf, bus.full}); end
        cmt();
        checks++;
        if ({bus.ovf, bus.full} !== 2'b00) begin errors++; $display("FAIL hold_commit got ovf/full=%b exp 00", {bus.ovf, bus.full}); end
        wr(8'hBB);
        checks++;
        if ({bus.ovf, bus.ne} !== 2'b01) begin errors++; $display("FAIL hold_accept got ovf/ne=%b exp 01", {bus.ovf, bus.ne}); end
        rd();
        checks++;
        if (bus.rd_data !== 8'hBB) begin errors++; $display("FAIL hold_read_bb got %0h exp bb", bus.rd_data); end
        cmt();
    endtask

    task automatic test_same_cycle();
        wr(8'h11);
        bus.re = 1'b1; bus.commit = 1'b1; tick(); idle();
        checks++;
        if ({bus.ne, bus.rd_data} !== {1'b0, 8'h11}) begin
            errors++; $display("FAIL re_commit got ne=%b data=%0h exp ne=0 data=11", bus.ne, bus.rd_data);
        end
        bus.rollback = 1'b1; tick(); idle();
        checks++;
        if (bus.ne !== 1'b0) begin errors++; $display("FAIL re_commit_retired got ne=%b exp 0", bus.ne); end
        wr(8'h33);
        bus.re = 1'b1; bus.rollback = 1'b1; tick(); idle();
        checks++;
        if ({bus.ne, bus.unf, bus.rd_data} !== {2'b10, 8'h11}) begin
            errors++; $display("FAIL re_rollback got ne=%b unf=%b data=%0h exp 1 0 11", bus.ne, bus.unf, bus.rd_data);
        end
        rd();
        checks++;
        if (bus.rd_data !== 8'h33) begin errors++; $display("FAIL pop_33 got %0h exp 33", bus.rd_data); end
        bus.commit = 1'b1; bus.rollback = 1'b1; tick(); idle();
        checks++;
        if (bus.ne !== 1'b1) begin errors++; $display("FAIL commit_rollback got ne=%b exp 1", bus.ne); end
        rd();
        checks++;
        if (bus.rd_data !== 8'h33) begin errors++; $display("FAIL replay_33 got %0h exp 33", bus.rd_data); end
        cmt();
        checks++;
        if (bus.ne !== 1'b0) begin errors++; $display("FAIL commit_33 got ne=%b exp 0", bus.ne); end
        bus.re = 1'b1; bus.rollback = 1'b1; tick(); idle();
        checks++;
        if (bus.unf !== 1'b0) begin errors++; $display("FAIL empty_re_rollback got unf=%b exp 0", bus.unf); end
        bus.we = 1'b1; bus.wr_data = 8'h55; bus.re = 1'b1; tick(); idle();
        checks++;
        if ({bus.unf, bus.ne, bus.rd_data} !== {2'b11, 8'h33}) begin
            errors++; $display("FAIL wr_re_empty got unf=%b ne=%b data=%0h exp 1 1 33", bus.unf, bus.ne, bus.rd_data);
        end
        rd();
        checks++;
        if ({bus.unf, bus.rd_data} !== {1'b0, 8'h55}) begin
            errors++; $display("FAIL wr_re_next got unf=%b data=%0h exp 0 55", bus.unf, bus.rd_data);
        end
        cmt();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) wr(8'(i));
        rd(); rd();
        checks++;
        if (bus.rd_data !== 8'h02) begin errors++; $display("FAIL mid_pre got %0h exp 2", bus.rd_data); end
        #2 reset_l = 1'b0;
        #1;
        checks++;
        if ({bus.ne, bus.full, bus.ovf, bus.unf, bus.rd_data} !== 12'h000) begin
            errors++; $display("FAIL mid_async got ne=%b full=%b ovf=%b unf=%b data=%0h exp all 0",
                               bus.ne, bus.full, bus.ovf, bus.unf, bus.rd_data);
        end
        tick();
        reset_l = 1'b1;
        tick();
        wr(8'h77);
        rd();
        checks++;
        if ({bus.ne, bus.rd_data} !== {1'b0, 8'h77}) begin
            errors++; $display("FAIL mid_after got ne=%b data=%0h exp ne=0 data=77", bus.ne, bus.rd_data);
        end
        cmt();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overfill();
        test_rollback();
        test_full_hold();
        test_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_fifo_rd_commit.md
Name: frame_fifo_rd_commit

Overview:
- Synchronous FIFO with transactional reads; the read-side counterpart of the write-side commit/rollback frame FIFO.
- The consumer pops entries speculatively. On `commit` the popped entries are retired and their space is freed. On `rollback` the read pointer rewinds to the last commit point so the frame can be re-sent.
- Sits between a buffered source and a retry-capable transmitter (e.g. a UART or packet link that must re-send on NAK).

Parameters:
- DATAWIDTH, 8, entry width in bits.
- ADDRWIDTH, 3, log2 of depth; DEPTH = 2**ADDRWIDTH entries.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_l  input  1  asynchronous active-low reset.
- wr_data  input  DATAWIDTH  write data.
- we  input  1  write enable.
- ovf  output  1  registered one-cycle pulse: write attempted while full; the data is dropped.
- rd_data  output  DATAWIDTH  registered read data, valid the cycle after an accepted re ("late").
- re  input  1  speculative pop.
- ne  output  1  unread (speculative) data available.
- unf  output  1  registered one-cycle pulse: re attempted while ne=0.
- commit  input  1  retire all entries popped so far, including any pop in the same cycle.
- rollback  input  1  rewind the read pointer to the last commit point.
- full  output  1  no free space, measured against the committed read pointer.

Behaviour:
- Pointers:
  - wr_ptr, rd_ptr (speculative) and rd_cmt (committed), each ADDRWIDTH+1 bits wide and wrapping modulo 2*DEPTH.
  - The RAM index is the low ADDRWIDTH bits.
- Status flags:
  - full = (wr_ptr - rd_cmt) == DEPTH.
  - ne = (wr_ptr != rd_ptr).
  - Both are combinational from registered pointers only.
- Write:
  - we with !full: store wr_data at wr_ptr, then wr_ptr+1.
  - we with full: no store and no pointer change; ovf=1 next cycle.
  - A commit in the same cycle does not unblock that write; full is evaluated on pre-edge state.
- Read:
  - re with ne: rd_data <= mem[rd_ptr] and rd_ptr+1; rd_data is valid one cycle after re.
  - re with !ne: no pointer change; rd_data holds; unf=1 next cycle.
  - A write in the same cycle to an empty FIFO is not readable until the following cycle.
- Commit: rd_cmt <= next value of rd_ptr, so a pop in the same cycle is included.
- Rollback:
  - rd_ptr <= rd_cmt.
  - Any re in the same cycle is ignored: no pop, no unf, rd_data holds.
  - Rollback has priority over commit; a simultaneous commit is ignored.
- Simultaneous we and re: independent, both honoured per the rules above.
- Reset (asynchronous, any time including mid-frame):
  - All pointers = 0; rd_data = 0; ovf = 0; unf = 0.
  - Hence ne = 0 and full = 0.
  - Uncommitted and unread contents are discarded.
  - RAM contents are not reset.
- Wrap-around: the extra MSB disambiguates full from empty; no special handling beyond modulo arithmetic.

Optional Feature:
- Macro: FRAME_FIFO_RD_LEVEL_EN.
- When defined, adds two outputs, both combinational from registered pointers:
  - wr_free (ADDRWIDTH+1 bits) = DEPTH - (wr_ptr - rd_cmt).
  - rd_avail (ADDRWIDTH+1 bits) = wr_ptr - rd_ptr.
- When undefined, these ports and their logic are absent. All other behaviour is identical either way.

Decomposition:
- Shared package holds:
  - Pointer-difference function (modulo subtraction on ADDRWIDTH+1 bits).
  - Depth constant helper (2**ADDRWIDTH).
- One sub-module: ram_sdp_reg, a simple dual-port RAM with one write port and one registered read port (DATAWIDTH, ADDRWIDTH). Its read-enable is driven by an accepted pop only.

Test Plan:
- Fill, commit, drain: write 1..8, re x9 then commit → rd_data sequence 1..8 on cycles after each re; unf pulses once on the 9th re; afterwards full=0, ne=0.
- Overfill: write 1..9 with no reads → full=1 after the 8th write; ovf pulses once for value 9; a drain returns 1..8 only.
- Rollback replay: write 1..4, read 1,2,3, rollback, read x4 → 1,2,3,4; commit → ne=0, full=0.
- Full holds until commit: fill 8 and read all 8 without committing → full stays 1 and a write of 0xAA gives ovf; then commit → full=0 and the next write is accepted.
- Same-cycle corner cases:
  - re+commit on the last entry → that entry is retired.
  - re+rollback → no pop and no unf.
  - commit+rollback → rollback only.
- Reset mid-frame: write 1..5, read 2, assert reset_l=0 asynchronously between edges → ne, full, ovf, unf and rd_data go to 0 immediately; a subsequent write/read returns the new data only.
